// File: rtl/rob_pkg.sv
// Shared constants and types for the ROB completion-writeback path.
package rob_pkg;

  localparam int unsigned ROB_DEPTH    = 128;
  localparam int unsigned ROB_IDX_W    = 7;
  localparam int unsigned ROB_WB_PORTS = 4;
  localparam int unsigned STALL_CNT_W  = 16;

  // One buffered completion report from a functional unit.
  typedef struct packed {
    logic [ROB_IDX_W-1:0] idx;
    logic                 exc;
  } wb_entry_t;

endpackage

// File: rtl/rob_wb_rr_select.sv
// Combinational round-robin pick of up to NUM_PORTS eligible units, with at
// most one exception-carrying unit selected per cycle.
module rob_wb_rr_select #(
  parameter int unsigned NUM_FU    = 8,
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned PTR_W     = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
  input  logic [NUM_FU-1:0]                eligible,
  input  logic [NUM_FU-1:0]                exc_mask,
  input  logic [PTR_W-1:0]                 rr_ptr,
  output logic [NUM_FU-1:0]                grant,
  output logic [NUM_PORTS-1:0]             port_valid,
  output logic [NUM_PORTS-1:0][PTR_W-1:0]  port_unit,
  output logic [PTR_W-1:0]                 next_ptr
);

  localparam int unsigned CNT_W  = $clog2(NUM_PORTS + 1);
  localparam int unsigned PIDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [PTR_W:0]   FU_LIMIT   = (PTR_W + 1)'(NUM_FU);
  localparam logic [CNT_W-1:0] PORT_LIMIT = CNT_W'(NUM_PORTS);

  logic [PTR_W:0]   cand;
  logic [PTR_W:0]   nxt;
  logic [CNT_W-1:0] used;
  logic             exc_used;

  // Walk units from rr_ptr with wrap; a second exception unit is skipped
  // rather than ending the scan, so later clean units can still be granted.
  always_comb begin
    grant      = '0;
    port_valid = '0;
    port_unit  = '0;
    next_ptr   = rr_ptr;
    used       = '0;
    exc_used   = 1'b0;
    cand       = '0;
    nxt        = '0;
    for (int unsigned k = 0; k < NUM_FU; k++) begin
      cand = {1'b0, rr_ptr} + (PTR_W + 1)'(k);
      if (cand >= FU_LIMIT) cand = cand - FU_LIMIT;
      if (eligible[cand[PTR_W-1:0]] && (used < PORT_LIMIT) &&
          !(exc_mask[cand[PTR_W-1:0]] && exc_used)) begin
        grant[cand[PTR_W-1:0]]        = 1'b1;
        port_valid[used[PIDX_W-1:0]]  = 1'b1;
        port_unit[used[PIDX_W-1:0]]   = cand[PTR_W-1:0];
        used                          = used + 1'b1;
        if (exc_mask[cand[PTR_W-1:0]]) exc_used = 1'b1;
        nxt = cand + 1'b1;
        if (nxt >= FU_LIMIT) nxt = nxt - FU_LIMIT;
        next_ptr = nxt[PTR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/rob_wb_arbiter.sv
// Completion-writeback arbiter: per-unit holding registers feeding the ROB's
// executed-marking ports and exception port through a round-robin selector.
module rob_wb_arbiter
  import rob_pkg::*;
#(
  parameter int unsigned NUM_FU    = 8,
  parameter int unsigned NUM_PORTS = ROB_WB_PORTS,
  parameter int unsigned IDX_W     = ROB_IDX_W
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_FU-1:0]                fu_valid,
  input  logic [NUM_FU-1:0][IDX_W-1:0]     fu_idx,
  input  logic [NUM_FU-1:0]                fu_exc,
  output logic [NUM_FU-1:0]                fu_ready,
  input  logic                             flush,
  output logic [NUM_PORTS-1:0]             executed,
  output logic [NUM_PORTS-1:0][IDX_W-1:0]  executed_idx,
  output logic                             exception,
  output logic [IDX_W-1:0]                 exception_idx,
  output logic [STALL_CNT_W-1:0]           stall_cnt
);

  localparam int unsigned PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [NUM_FU-1:0]               hv_q, hv_d;
  wb_entry_t [NUM_FU-1:0]          hold_q, hold_d;
  logic [PTR_W-1:0]                rr_ptr_q, rr_ptr_d;
  logic [NUM_PORTS-1:0]            executed_q, executed_d;
  logic [NUM_PORTS-1:0][IDX_W-1:0] executed_idx_q, executed_idx_d;
  logic                            exception_q, exception_d;
  logic [IDX_W-1:0]                exception_idx_q, exception_idx_d;
  logic [STALL_CNT_W-1:0]          stall_cnt_q, stall_cnt_d;

  logic [NUM_FU-1:0]               exc_mask;
  logic [NUM_FU-1:0]               grant;
  logic [NUM_PORTS-1:0]            port_valid;
  logic [NUM_PORTS-1:0][PTR_W-1:0] port_unit;
  logic [PTR_W-1:0]                next_ptr;
  logic                            stall;

  // Expose the buffered exception flags to the selector.
  always_comb begin
    exc_mask = '0;
    for (int unsigned i = 0; i < NUM_FU; i++) exc_mask[i] = hold_q[i].exc;
  end

  rob_wb_rr_select #(
    .NUM_FU    (NUM_FU),
    .NUM_PORTS (NUM_PORTS),
    .PTR_W     (PTR_W)
  ) u_select (
    .eligible   (hv_q),
    .exc_mask   (exc_mask),
    .rr_ptr     (rr_ptr_q),
    .grant      (grant),
    .port_valid (port_valid),
    .port_unit  (port_unit),
    .next_ptr   (next_ptr)
  );

  // A slot can accept when empty or when it is being drained this cycle.
  always_comb begin
    fu_ready = {NUM_FU{reset & ~flush}} & (~hv_q | grant);
  end

  // Holding registers and round-robin pointer; flush drops everything buffered.
  always_comb begin
    hv_d     = hv_q;
    hold_d   = hold_q;
    rr_ptr_d = flush ? rr_ptr_q : next_ptr;
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      if (grant[i]) hv_d[i] = 1'b0;
      if (fu_valid[i] && fu_ready[i]) begin
        hv_d[i]       = 1'b1;
        hold_d[i].idx = ROB_IDX_W'(fu_idx[i]);
        hold_d[i].exc = fu_exc[i];
      end
    end
    if (flush) hv_d = '0;
  end

  // Registered ROB-facing outputs; the exception grant also marks executed.
  always_comb begin
    executed_d      = port_valid;
    executed_idx_d  = '0;
    exception_d     = 1'b0;
    exception_idx_d = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (port_valid[p]) begin
        executed_idx_d[p] = IDX_W'(hold_q[port_unit[p]].idx);
        if (hold_q[port_unit[p]].exc) begin
          exception_d     = 1'b1;
          exception_idx_d = IDX_W'(hold_q[port_unit[p]].idx);
        end
      end
    end
    if (flush) begin
      executed_d      = '0;
      executed_idx_d  = '0;
      exception_d     = 1'b0;
      exception_idx_d = '0;
    end
  end

  // Grants are a subset of eligible units, so any eligible-but-ungranted unit
  // means bandwidth fell short this cycle.
  always_comb begin
    stall       = |(hv_q & ~grant);
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hv_q            <= '0;
      hold_q          <= '0;
      rr_ptr_q        <= '0;
      executed_q      <= '0;
      executed_idx_q  <= '0;
      exception_q     <= 1'b0;
      exception_idx_q <= '0;
      stall_cnt_q     <= '0;
    end else begin
      hv_q            <= hv_d;
      hold_q          <= hold_d;
      rr_ptr_q        <= rr_ptr_d;
      executed_q      <= executed_d;
      executed_idx_q  <= executed_idx_d;
      exception_q     <= exception_d;
      exception_idx_q <= exception_idx_d;
      stall_cnt_q     <= stall_cnt_d;
    end
  end

  assign executed      = executed_q;
  assign executed_idx  = executed_idx_q;
  assign exception     = exception_q;
  assign exception_idx = exception_idx_q;
  assign stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_rob_wb_arbiter.sv
// Scenario bench for rob_wb_arbiter with a queue of expected output words.
module tb_rob_wb_arbiter;

  logic             clk = 1'b0;
  logic             reset;
  logic [7:0]       fu_valid;
  logic [7:0][6:0]  fu_idx;
  logic [7:0]       fu_exc;
  logic [7:0]       fu_ready;
  logic             flush;
  logic [3:0]       executed;
  logic [3:0][6:0]  executed_idx;
  logic             exception;
  logic [6:0]       exception_idx;
  logic [15:0]      stall_cnt;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // {executed, idx3, idx2, idx1, idx0, exception, exception_idx}
  logic [39:0] exp_q[$];
  logic [39:0] exp_w;
  logic [39:0] obs_w;

  assign obs_w = {executed, executed_idx, exception, exception_idx};

  rob_wb_arbiter #(
    .NUM_FU    (8),
    .NUM_PORTS (4),
    .IDX_W     (7)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .fu_valid      (fu_valid),
    .fu_idx        (fu_idx),
    .fu_exc        (fu_exc),
    .fu_ready      (fu_ready),
    .flush         (flush),
    .executed      (executed),
    .executed_idx  (executed_idx),
    .exception     (exception),
    .exception_idx (exception_idx),
    .stall_cnt     (stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [39:0] ev(input logic [3:0] ex, input logic [6:0] i0,
                                     input logic [6:0] i1, input logic [6:0] i2,
                                     input logic [6:0] i3, input logic e,
                                     input logic [6:0] ei);
    return {ex, i3, i2, i1, i0, e, ei};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; flush = 1'b0; fu_valid = '1; fu_exc = '0; fu_idx = '0;
    repeat (3) tick();
    checks++;
    if (fu_ready !== 8'h00) begin errors++; $display("FAIL reset_ready: got %h want 00", fu_ready); end
    checks++;
    if (executed !== 4'b0000) begin errors++; $display("FAIL reset_executed: got %b want 0000", executed); end
    checks++;
    if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall: got %0d want 0", stall_cnt); end
    reset = 1'b1; fu_valid = '0;
    #1;
    checks++;
    if (fu_ready !== 8'hFF) begin errors++; $display("FAIL release_ready: got %h want FF", fu_ready); end
  endtask

  task automatic test_oversubscribe();
    fu_valid = '1; fu_exc = '0;
    for (int i = 0; i < 8; i++) fu_idx[i] = 7'(10 + i);
    exp_q.push_back(ev(4'b1111, 7'd10, 7'd11, 7'd12, 7'd13, 1'b0, 7'd0));
    exp_q.push_back(ev(4'b1111, 7'd14, 7'd15, 7'd16, 7'd17, 1'b0, 7'd0));
    tick();
    fu_valid = '0;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL oversub_q%0d: queue empty", c); end
      else begin
        exp_w = exp_q.pop_front();
        if (obs_w !== exp_w) begin errors++; $display("FAIL oversub_c%0d: got %h want %h", c, obs_w, exp_w); end
      end
    end
    checks++;
    if (stall_cnt !== 16'd1) begin errors++; $display("FAIL oversub_stall: got %0d want 1", stall_cnt); end
  endtask

  task automatic test_exception_limit();
    fu_valid = 8'b0000_1110; fu_exc = 8'b0000_1010;
    fu_idx[1] = 7'd50; fu_idx[3] = 7'd51; fu_idx[2] = 7'd52;
    exp_q.push_back(ev(4'b0011, 7'd50, 7'd52, 7'd0, 7'd0, 1'b1, 7'd50));
    exp_q.push_back(ev(4'b0001, 7'd51, 7'd0, 7'd0, 7'd0, 1'b1, 7'd51));
    tick();
    fu_valid = '0; fu_exc = '0;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL exc_q%0d: queue empty", c); end
      else begin
        exp_w = exp_q.pop_front();
        if (obs_w !== exp_w) begin errors++; $display("FAIL exc_c%0d: got %h want %h", c, obs_w, exp_w); end
      end
    end
    checks++;
    if (stall_cnt !== 16'd2) begin errors++; $display("FAIL exc_stall: got %0d want 2", stall_cnt); end
  endtask

  task automatic test_single();
    fu_valid = 8'b0000_0100; fu_idx[2] = 7'd37; fu_exc = '0;
    exp_q.push_back(ev(4'b0001, 7'd37, 7'd0, 7'd0, 7'd0, 1'b0, 7'd0));
    exp_q.push_back(ev(4'b0000, 7'd0, 7'd0, 7'd0, 7'd0, 1'b0, 7'd0));
    tick();
    fu_valid = '0;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL single_q%0d: queue empty", c); end
      else begin
        exp_w = exp_q.pop_front();
        if (obs_w !== exp_w) begin errors++; $display("FAIL single_c%0d: got %h want %h", c, obs_w, exp_w); end
      end
    end
  endtask

  task automatic test_flush();
    fu_valid = 8'b0011_1111; fu_exc = '0;
    for (int i = 0; i < 6; i++) fu_idx[i] = 7'(20 + i);
    tick();
    flush = 1'b1; fu_valid = 8'b0000_0001; fu_idx[0] = 7'd99;
    #1;
    checks++;
    if (fu_ready !== 8'h00) begin errors++; $display("FAIL flush_ready: got %h want 00", fu_ready); end
    exp_q.push_back(ev(4'b0000, 7'd0, 7'd0, 7'd0, 7'd0, 1'b0, 7'd0));
    exp_q.push_back(ev(4'b0000, 7'd0, 7'd0, 7'd0, 7'd0, 1'b0, 7'd0));
    tick();
    flush = 1'b0; fu_valid = '0;
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL flush_q0: queue empty"); end
    else begin
      exp_w = exp_q.pop_front();
      if (obs_w !== exp_w) begin errors++; $display("FAIL flush_c0: got %h want %h", obs_w, exp_w); end
    end
    #1;
    checks++;
    if (fu_ready !== 8'hFF) begin errors++; $display("FAIL flush_hv_clear: ready got %h want FF", fu_ready); end
    tick();
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL flush_q1: queue empty"); end
    else begin
      exp_w = exp_q.pop_front();
      if (obs_w !== exp_w) begin errors++; $display("FAIL flush_c1: got %h want %h", obs_w, exp_w); end
    end
  endtask

  task automatic test_back_to_back();
    fu_exc = '0;
    for (int k = 0; k < 3; k++) begin
      fu_valid = 8'b0100_0000; fu_idx[6] = 7'(100 + k);
      exp_q.push_back(ev(4'b0001, 7'(100 + k), 7'd0, 7'd0, 7'd0, 1'b0, 7'd0));
      #1;
      checks++;
      if (fu_ready[6] !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d: got %b want 1", k, fu_ready[6]); end
      tick();
      if (k > 0) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_q%0d: queue empty", k); end
        else begin
          exp_w = exp_q.pop_front();
          if (obs_w !== exp_w) begin errors++; $display("FAIL b2b_c%0d: got %h want %h", k, obs_w, exp_w); end
        end
      end
    end
    fu_valid = '0;
    tick();
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_qlast: queue empty"); end
    else begin
      exp_w = exp_q.pop_front();
      if (obs_w !== exp_w) begin errors++; $display("FAIL b2b_last: got %h want %h", obs_w, exp_w); end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_oversubscribe();
    test_exception_limit();
    test_single();
    test_flush();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL leftover_expect: got %0d want 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
